note_envelope: RTL and testbench

Per-voice note and amplitude controller sitting directly downstream of the keycode decoder. It consumes the 14 one-hot piano key flags, selects the active note, and produces the matching oscillator phase increment. It runs a four-phase attack/decay/sustain/release amplitude envelope, advanced once per audio sample tick, and feeds the oscillator and the output multiplier.

---
 rtl/note_envelope.sv | 146 ++++++++++++++
 tb/tb_note_envelope.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/note_envelope.sv
// rtl/note_envelope.sv - per-voice note select, phase increment ROM and ADSR envelope
// Lowest pressed key wins; all state advances only on sample_tick.
module note_envelope #(
  parameter int unsigned ATTACK_STEP  = 4,
  parameter int unsigned DECAY_STEP   = 1,
  parameter int unsigned SUSTAIN_LVL  = 192,
  parameter int unsigned RELEASE_STEP = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        sample_tick,
  input  logic [13:0] key_on,
  output logic [3:0]  note_idx,
  output logic [19:0] phase_inc,
  output logic [7:0]  amp,
  output logic        gate,
  output logic        active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [8:0] ATK9 = 9'(ATTACK_STEP);
  localparam logic [8:0] DEC9 = 9'(DECAY_STEP);
  localparam logic [8:0] SUS9 = 9'(SUSTAIN_LVL);
  localparam logic [7:0] DEC8 = 8'(DECAY_STEP);
  localparam logic [7:0] SUS8 = 8'(SUSTAIN_LVL);
  localparam logic [7:0] REL8 = 8'(RELEASE_STEP);

  state_t      state_q, state_d;
  logic [3:0]  note_idx_q, note_idx_d;
  logic [19:0] phase_inc_q, phase_inc_d;
  logic [7:0]  amp_q, amp_d;
  logic        gate_q, gate_d;
  logic        active_q, active_d;

  logic        pressed;
  logic [3:0]  sel;
  logic [8:0]  atk_sum;
  logic        atk_sat;
  logic        dec_floor;
  logic        rel_floor;
  logic        do_atk, do_dec, do_rel;

  // round(f * 2^20 / 48000) for C4..D5
  function automatic logic [19:0] phase_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    phase_rom = 20'd5715;
      4'd1:    phase_rom = 20'd6055;
      4'd2:    phase_rom = 20'd6415;
      4'd3:    phase_rom = 20'd6797;
      4'd4:    phase_rom = 20'd7201;
      4'd5:    phase_rom = 20'd7629;
      4'd6:    phase_rom = 20'd8083;
      4'd7:    phase_rom = 20'd8563;
      4'd8:    phase_rom = 20'd9072;
      4'd9:    phase_rom = 20'd9612;
      4'd10:   phase_rom = 20'd10184;
      4'd11:   phase_rom = 20'd10789;
      4'd12:   phase_rom = 20'd11431;
      4'd13:   phase_rom = 20'd12830;
      default: phase_rom = 20'd0;
    endcase
  endfunction

  always_comb begin
    sel = 4'd0;
    for (int i = 13; i >= 0; i--) begin
      if (key_on[i]) sel = 4'(i);
    end
  end

  assign pressed   = |key_on;
  assign atk_sum   = {1'b0, amp_q} + ATK9;
  assign atk_sat   = atk_sum >= 9'd255;
  assign dec_floor = {1'b0, amp_q} <= (SUS9 + DEC9);
  assign rel_floor = amp_q <= REL8;

  always_comb begin
    state_d     = state_q;
    amp_d       = amp_q;
    note_idx_d  = note_idx_q;
    phase_inc_d = phase_inc_q;
    do_atk      = 1'b0;
    do_dec      = 1'b0;
    do_rel      = 1'b0;

    if (sample_tick) begin
      if (pressed && (state_q == IDLE || state_q == RELEASE || sel != note_idx_q)) begin
        // new note or legato: attack continues from the current amplitude
        note_idx_d  = sel;
        phase_inc_d = phase_rom(sel);
        do_atk      = 1'b1;
      end else if (pressed) begin
        do_atk = (state_q == ATTACK);
        do_dec = (state_q == DECAY);
      end else if (state_q != IDLE) begin
        do_rel = 1'b1;
      end
    end

    if (do_atk) begin
      amp_d   = atk_sat ? 8'd255 : atk_sum[7:0];
      state_d = atk_sat ? DECAY : ATTACK;
    end else if (do_dec) begin
      amp_d   = dec_floor ? SUS8 : (amp_q - DEC8);
      state_d = dec_floor ? SUSTAIN : DECAY;
    end else if (do_rel) begin
      amp_d   = rel_floor ? 8'd0 : (amp_q - REL8);
      state_d = rel_floor ? IDLE : RELEASE;
    end

    gate_d   = (state_d == ATTACK) || (state_d == DECAY) || (state_d == SUSTAIN);
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      note_idx_q  <= 4'd0;
      phase_inc_q <= 20'd0;
      amp_q       <= 8'd0;
      gate_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      note_idx_q  <= note_idx_d;
      phase_inc_q <= phase_inc_d;
      amp_q       <= amp_d;
      gate_q      <= gate_d;
      active_q    <= active_d;
    end
  end

  assign note_idx  = note_idx_q;
  assign phase_inc = phase_inc_q;
  assign amp       = amp_q;
  assign gate      = gate_q;
  assign active    = active_q;

endmodule

// File: tb/tb_note_envelope.sv
// tb/tb_note_envelope.sv - directed self-checking bench for note_envelope
module tb_note_envelope;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic [13:0] key_on = 14'd0;
  logic [3:0]  note_idx;
  logic [19:0] phase_inc;
  logic [7:0]  amp;
  logic        gate;
  logic        active;

  int checks = 0;
  int errors = 0;

  note_envelope dut (
    .Clk(Clk),
    .Reset(Reset),
    .sample_tick(sample_tick),
    .key_on(key_on),
    .note_idx(note_idx),
    .phase_inc(phase_inc),
    .amp(amp),
    .gate(gate),
    .active(active)
  );

  always #5 Clk = ~Clk;

  // n consecutive tick cycles; outputs are sampled 1 time unit after the last edge
  task automatic do_ticks(input int n);
    @(negedge Clk);
    sample_tick = 1'b1;
    repeat (n) @(posedge Clk);
    #1;
    sample_tick = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (amp !== 8'd0) begin errors++; $display("FAIL reset_amp got %0d exp 0", amp); end
    checks++; if (note_idx !== 4'd0) begin errors++; $display("FAIL reset_note got %0d exp 0", note_idx); end
    checks++; if (phase_inc !== 20'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase_inc); end
    checks++; if (gate !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL reset_flags got gate=%0b active=%0b exp 0 0", gate, active); end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_attack_decay;
    @(negedge Clk);
    key_on = 14'h0200;
    do_ticks(1);
    checks++; if (note_idx !== 4'd9) begin errors++; $display("FAIL atk_note got %0d exp 9", note_idx); end
    checks++; if (phase_inc !== 20'd9612) begin errors++; $display("FAIL atk_phase got %0d exp 9612", phase_inc); end
    checks++; if (gate !== 1'b1 || active !== 1'b1) begin errors++; $display("FAIL atk_flags got gate=%0b active=%0b exp 1 1", gate, active); end
    checks++; if (amp !== 8'd4) begin errors++; $display("FAIL atk_t1_amp got %0d exp 4", amp); end
    do_ticks(62);
    checks++; if (amp !== 8'd252) begin errors++; $display("FAIL atk_t63_amp got %0d exp 252", amp); end
    do_ticks(1);
    checks++; if (amp !== 8'd255) begin errors++; $display("FAIL atk_t64_amp got %0d exp 255", amp); end
    do_ticks(1);
    checks++; if (amp !== 8'd254) begin errors++; $display("FAIL decay_t65_amp got %0d exp 254", amp); end
    do_ticks(61);
    checks++; if (amp !== 8'd193) begin errors++; $display("FAIL decay_t126_amp got %0d exp 193", amp); end
    do_ticks(1);
    checks++; if (amp !== 8'd192) begin errors++; $display("FAIL decay_t127_amp got %0d exp 192", amp); end
    do_ticks(5);
    checks++; if (amp !== 8'd192 || gate !== 1'b1) begin errors++; $display("FAIL sustain_hold got amp=%0d gate=%0b exp 192 1", amp, gate); end
  endtask

  task automatic test_release;
    @(negedge Clk);
    key_on = 14'd0;
    do_ticks(1);
    checks++; if (gate !== 1'b0 || active !== 1'b1) begin errors++; $display("FAIL rel_flags got gate=%0b active=%0b exp 0 1", gate, active); end
    checks++; if (amp !== 8'd191) begin errors++; $display("FAIL rel_t1_amp got %0d exp 191", amp); end
    checks++; if (note_idx !== 4'd9) begin errors++; $display("FAIL rel_note got %0d exp 9", note_idx); end
    do_ticks(190);
    checks++; if (amp !== 8'd1 || active !== 1'b1) begin errors++; $display("FAIL rel_t191 got amp=%0d active=%0b exp 1 1", amp, active); end
    do_ticks(1);
    checks++; if (amp !== 8'd0 || active !== 1'b0) begin errors++; $display("FAIL rel_t192 got amp=%0d active=%0b exp 0 0", amp, active); end
    do_ticks(3);
    checks++; if (amp !== 8'd0 || active !== 1'b0) begin errors++; $display("FAIL idle_hold got amp=%0d active=%0b exp 0 0", amp, active); end
    checks++; if (note_idx !== 4'd9 || phase_inc !== 20'd9612) begin errors++; $display("FAIL idle_pitch got note=%0d phase=%0d exp 9 9612", note_idx, phase_inc); end
  endtask

  task automatic test_priority;
    @(negedge Clk);
    key_on = 14'h0201;
    do_ticks(1);
    checks++; if (note_idx !== 4'd0) begin errors++; $display("FAIL prio_note got %0d exp 0", note_idx); end
    checks++; if (phase_inc !== 20'd5715) begin errors++; $display("FAIL prio_phase got %0d exp 5715", phase_inc); end
    checks++; if (amp !== 8'd4) begin errors++; $display("FAIL prio_amp got %0d exp 4", amp); end
    @(negedge Clk);
    key_on = 14'h0020;
    idle_cycles(3);
    @(negedge Clk);
    key_on = 14'd0;
    idle_cycles(2);
    checks++; if (note_idx !== 4'd0 || phase_inc !== 20'd5715) begin errors++; $display("FAIL notick_pitch got note=%0d phase=%0d exp 0 5715", note_idx, phase_inc); end
    checks++; if (amp !== 8'd4 || gate !== 1'b1) begin errors++; $display("FAIL notick_env got amp=%0d gate=%0b exp 4 1", amp, gate); end
    @(negedge Clk);
    key_on = 14'h0201;
    do_ticks(126);
    checks++; if (amp !== 8'd192 || note_idx !== 4'd0) begin errors++; $display("FAIL prio_sustain got amp=%0d note=%0d exp 192 0", amp, note_idx); end
  endtask

  task automatic test_legato;
    @(negedge Clk);
    key_on = 14'h1000;
    do_ticks(1);
    checks++; if (note_idx !== 4'd12) begin errors++; $display("FAIL legato_note got %0d exp 12", note_idx); end
    checks++; if (phase_inc !== 20'd11431) begin errors++; $display("FAIL legato_phase got %0d exp 11431", phase_inc); end
    checks++; if (amp !== 8'd196 || gate !== 1'b1) begin errors++; $display("FAIL legato_amp got amp=%0d gate=%0b exp 196 1", amp, gate); end
    do_ticks(1);
    checks++; if (amp !== 8'd200) begin errors++; $display("FAIL legato_attack got %0d exp 200", amp); end
  endtask

  task automatic test_retrigger;
    @(negedge Clk);
    key_on = 14'd0;
    do_ticks(100);
    checks++; if (amp !== 8'd100 || gate !== 1'b0) begin errors++; $display("FAIL retrig_pre got amp=%0d gate=%0b exp 100 0", amp, gate); end
    @(negedge Clk);
    key_on = 14'h2000;
    do_ticks(1);
    checks++; if (amp !== 8'd104 || gate !== 1'b1) begin errors++; $display("FAIL retrig_amp got amp=%0d gate=%0b exp 104 1", amp, gate); end
    checks++; if (note_idx !== 4'd13 || phase_inc !== 20'd12830) begin errors++; $display("FAIL retrig_pitch got note=%0d phase=%0d exp 13 12830", note_idx, phase_inc); end
    do_ticks(1);
    checks++; if (amp !== 8'd108) begin errors++; $display("FAIL retrig_attack got %0d exp 108", amp); end
  endtask

  task automatic test_reset_mid;
    @(negedge Clk);
    Reset = 1'b1;
    sample_tick = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    sample_tick = 1'b0;
    checks++; if (amp !== 8'd0 || note_idx !== 4'd0 || phase_inc !== 20'd0) begin errors++; $display("FAIL midreset_vals got amp=%0d note=%0d phase=%0d exp 0 0 0", amp, note_idx, phase_inc); end
    checks++; if (gate !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL midreset_flags got gate=%0b active=%0b exp 0 0", gate, active); end
  endtask

  task automatic test_back_to_back;
    @(negedge Clk);
    key_on = 14'h0004;
    do_ticks(3);
    checks++; if (amp !== 8'd12 || note_idx !== 4'd2) begin errors++; $display("FAIL b2b got amp=%0d note=%0d exp 12 2", amp, note_idx); end
    checks++; if (phase_inc !== 20'd6415) begin errors++; $display("FAIL b2b_phase got %0d exp 6415", phase_inc); end
  endtask

  initial begin
    test_reset;
    test_attack_decay;
    test_release;
    test_priority;
    test_legato;
    test_retrigger;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
